// File: rtl/pc_seq.sv
// Registered program-counter sequencer: JR/JAL/branch redirects, link value and a retired counter.
// Optional misaligned-JR fault state is compiled in with `define PC_ALIGN_CHECK_EN.
module pc_seq #(
  parameter int          AW        = 32,
  parameter int          CW        = 16,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] FAULT_VEC = 32'h0000_0080
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          branch,
  input  logic          bne,
  input  logic          zero,
  input  logic          jal,
  input  logic          jr,
  input  logic [15:0]   imm,
  input  logic [25:0]   jtarget,
  input  logic [AW-1:0] rs_val,
  input  logic          fault_clr,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] link_pc,
  output logic [CW-1:0] retired,
  output logic          fault,
  output logic [AW-1:0] fault_pc
);

  // Region bits kept from pc4 on JAL; empty when AW <= 28.
  localparam logic [31:0] JAL_HI_KEEP = 32'hF000_0000;

  logic [AW-1:0]        pc_q, pc_d;
  logic [CW-1:0]        ret_q, ret_d;
  logic [AW-1:0]        pc4;
  logic signed [AW-1:0] imm_sx;
  logic [AW-1:0]        br_tgt;
  logic [AW-1:0]        jal_tgt;
  logic [AW-1:0]        jr_tgt;
  logic [AW-1:0]        nxt_pc;
  logic                 taken;

  assign pc4     = pc_q + AW'(4);
  assign imm_sx  = AW'(signed'(imm));
  assign br_tgt  = pc4 + AW'(imm_sx <<< 2);
  assign jal_tgt = (pc4 & JAL_HI_KEEP[AW-1:0]) | AW'({jtarget, 2'b00});
  assign taken   = branch & (zero ^ bne);

  always_comb begin
    if (jr)         nxt_pc = jr_tgt;
    else if (jal)   nxt_pc = jal_tgt;
    else if (taken) nxt_pc = br_tgt;
    else            nxt_pc = pc4;
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] fault_pc_q, fault_pc_d;
  logic          misalign;

  assign misalign = jr & (rs_val[1:0] != 2'b00);
  assign jr_tgt   = rs_val;
  assign fault    = (state_q == ST_FAULT);
  assign fault_pc = fault_pc_q;

  always_comb begin
    state_d    = state_q;
    fault_pc_d = fault_pc_q;
    pc_d       = pc_q;
    ret_d      = ret_q;
    if (state_q == ST_FAULT) begin
      if (fault_clr) begin
        pc_d    = AW'(FAULT_VEC);
        state_d = ST_RUN;
      end
    end else if (!stall) begin
      if (misalign) begin
        state_d    = ST_FAULT;
        fault_pc_d = rs_val;
      end else begin
        pc_d  = nxt_pc;
        ret_d = ret_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_pc_q <= fault_pc_d;
    end
  end
`else
  logic unused_ok;

  // Without the check a misaligned JR target is silently word-aligned.
  assign jr_tgt    = {rs_val[AW-1:2], 2'b00};
  assign fault     = 1'b0;
  assign fault_pc  = '0;
  assign unused_ok = &{1'b0, fault_clr, rs_val[1:0]};

  always_comb begin
    pc_d  = pc_q;
    ret_d = ret_q;
    if (!stall) begin
      pc_d  = nxt_pc;
      ret_d = ret_q + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= AW'(RESET_VEC);
      ret_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ret_q <= ret_d;
    end
  end

  assign pc      = pc_q;
  assign link_pc = pc4;
  assign retired = ret_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a 32-bit/16-bit-counter instance and a 16-bit/4-bit-counter instance
// share stimulus and are compared against an arithmetic reference model every cycle.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst, stall, branch, bne, zero, jal, jr, fault_clr;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] rs_val;

  logic [31:0] pc0, lk0, fp0;
  logic [15:0] rt0;
  logic        f0;
  logic [15:0] pc1, lk1, fp1;
  logic [3:0]  rt1;
  logic        f1;

  int checks = 0;
  int errors = 0;

  longint unsigned mpc[2], mret[2], mfpc[2];
  bit              mflt[2];
  int              aws[2] = '{32, 16};
  int              cws[2] = '{16, 4};

  always #5 clk = ~clk;

  pc_seq #(.AW(32), .CW(16)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .bne(bne), .zero(zero),
    .jal(jal), .jr(jr), .imm(imm), .jtarget(jtarget), .rs_val(rs_val),
    .fault_clr(fault_clr), .pc(pc0), .link_pc(lk0), .retired(rt0), .fault(f0),
    .fault_pc(fp0)
  );

  pc_seq #(.AW(16), .CW(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .bne(bne), .zero(zero),
    .jal(jal), .jr(jr), .imm(imm), .jtarget(jtarget), .rs_val(rs_val[15:0]),
    .fault_clr(fault_clr), .pc(pc1), .link_pc(lk1), .retired(rt1), .fault(f1),
    .fault_pc(fp1)
  );

  function automatic longint unsigned amask(int k);
    return (64'd1 << aws[k]) - 64'd1;
  endfunction

  // One clock of the architectural rules, applied to instance k.
  function automatic void model_step(int k);
    longint unsigned am, rsv, pc4, tgt;
    longint          off;
    am = amask(k);
    if (rst) begin
      mpc[k] = 0; mret[k] = 0; mflt[k] = 0; mfpc[k] = 0;
      return;
    end
    if (mflt[k]) begin
      if (fault_clr) begin
        mpc[k]  = 64'h80 & am;
        mflt[k] = 0;
      end
      return;
    end
    if (stall) return;
    rsv = longint'(rs_val) & am;
`ifdef PC_ALIGN_CHECK_EN
    if (jr && (rsv % 4 != 0)) begin
      mflt[k] = 1;
      mfpc[k] = rsv;
      return;
    end
`endif
    pc4 = (mpc[k] + 4) & am;
    if (jr) tgt = rsv - (rsv % 4);
    else if (jal) begin
      tgt = longint'(jtarget) * 4;
      if (aws[k] > 28) tgt = tgt + ((pc4 >> 28) << 28);
    end else if (branch && (zero != bne)) begin
      off = longint'($signed(imm)) * 4;
      tgt = pc4 + off;
    end else tgt = pc4;
    mpc[k]  = tgt & am;
    mret[k] = (mret[k] + 1) % (64'd1 << cws[k]);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("pc0",    64'(pc0), mpc[0]);
    chk("link0",  64'(lk0), (mpc[0] + 4) & amask(0));
    chk("ret0",   64'(rt0), mret[0]);
    chk("fault0", 64'(f0),  64'(mflt[0]));
    chk("fpc0",   64'(fp0), mfpc[0]);
    chk("pc1",    64'(pc1), mpc[1]);
    chk("link1",  64'(lk1), (mpc[1] + 4) & amask(1));
    chk("ret1",   64'(rt1), mret[1]);
    chk("fault1", 64'(f1),  64'(mflt[1]));
    chk("fpc1",   64'(fp1), mfpc[1]);
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    rst = 0; stall = 0; branch = 0; bne = 0; zero = 0; jal = 0; jr = 0;
    fault_clr = 0; imm = '0; jtarget = '0; rs_val = '0;
  endtask

  task automatic goto_pc(logic [31:0] a);
    idle(); jr = 1; rs_val = a; step(); idle();
  endtask

  initial begin
    idle();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 0; mret[k] = 0; mfpc[k] = 0; mflt[k] = 0;
    end
    rst = 1; step(); rst = 0;
    chk("rst_link", 64'(lk0), 64'h4);
    step(); step(); step();
    chk("seq_pc", 64'(pc0), 64'hC);
    chk("seq_ret", 64'(rt0), 64'h3);
    stall = 1; rst = 1; step(); idle();
    chk("rst_stall_pc", 64'(pc0), 64'h0);
    chk("rst_stall_ret", 64'(rt0), 64'h0);

    goto_pc(32'h40); branch = 1; zero = 1; imm = 16'hFFFE; step();
    chk("beq_taken", 64'(pc0), 64'h3C);
    goto_pc(32'h40); branch = 1; zero = 0; imm = 16'hFFFE; step();
    chk("beq_not", 64'(pc0), 64'h44);
    goto_pc(32'h40); branch = 1; bne = 1; zero = 0; imm = 16'hFFFE; step();
    chk("bne_taken", 64'(pc0), 64'h3C);

    goto_pc(32'h1000_0010); jal = 1; jtarget = 26'h0000100;
    #1 chk("jal_link", 64'(lk0), 64'h1000_0014);
    step();
    chk("jal_pc", 64'(pc0), 64'h1000_0400);
    idle(); jal = 1; jr = 1; rs_val = 32'h200; step();
    chk("jr_prio", 64'(pc0), 64'h200);

    idle(); stall = 1; jal = 1; jtarget = 26'h40;
    for (int i = 0; i < 4; i++) step();
    chk("stall_pc", 64'(pc0), 64'h200);
    stall = 0; step();
    chk("stall_rel", 64'(pc0), 64'h100);

    idle(); jr = 1; rs_val = 32'h102; step();
`ifdef PC_ALIGN_CHECK_EN
    chk("flt_set", 64'(f0), 64'h1);
    chk("flt_pc", 64'(fp0), 64'h102);
    chk("flt_hold", 64'(pc0), 64'h100);
`else
    chk("jr_align", 64'(pc0), 64'h100);
`endif
    for (int i = 0; i < 5; i++) begin
      idle(); stall = i[0]; jal = 1; jtarget = 26'($urandom); branch = 1; zero = 1;
      step();
    end
    idle(); fault_clr = 1; step();
`ifdef PC_ALIGN_CHECK_EN
    chk("flt_clr_pc", 64'(pc0), 64'h80);
    chk("flt_clr", 64'(f0), 64'h0);
`endif

    goto_pc(32'hFFFF_FFFC); step();
    chk("wrap_pc0", 64'(pc0), 64'h0);
    chk("wrap_pc1", 64'(pc1), 64'h0);

    idle(); rst = 1; step(); rst = 0;
    for (int i = 0; i < 16; i++) step();
    chk("ret_wrap", 64'(rt1), 64'h0);

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom % 50) == 0;
      stall     = ($urandom % 4) == 0;
      branch    = 1'($urandom);
      bne       = 1'($urandom);
      zero      = 1'($urandom);
      jal       = ($urandom % 5) == 0;
      jr        = ($urandom % 6) == 0;
      imm       = 16'($urandom);
      jtarget   = 26'($urandom);
      rs_val    = $urandom & ((($urandom % 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      fault_clr = ($urandom % 3) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
